mem_req_sequencer: RTL
======================

Name: mem_req_sequencer

Overview:
Shares the single 16-bit CPU memory port between the instruction-fetch requester and the data (execute/mem) requester. It arbitrates with data priority and an anti-starvation guard. It splits 32-bit data accesses into two 16-bit beats (low beat at addr, high beat at addr+1) and returns read data with valid pulses. It sits between write_back_fetch/execute_mem and the top-level mem_* ports of cpu.

Parameters:
ADDR_WIDTH, 8, width of all memory addresses
STARVE_MAX, 3, consecutive data grants allowed while fetch waits before fetch is forced (legal 1..15)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request (level, held until if_gnt_o)
if_addr_i  in  ADDR_WIDTH  fetch address
if_flush_i  in  1  branch taken; discard in-flight fetch response
if_gnt_o  out  1  one-cycle fetch accept pulse
if_rvalid_o  out  1  one-cycle fetch data valid
if_rdata_o  out  16  fetched instruction
d_req_i  in  1  data request (level, held until d_gnt_o)
d_we_i  in  1  1=write, 0=read
d_wide_i  in  1  1=32-bit access, 0=16-bit
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  32  write data; bits 15:0 used when d_wide_i=0
d_gnt_o  out  1  one-cycle data accept pulse
d_rvalid_o  out  1  one-cycle read data valid
d_rdata_o  out  32  read data; 16-bit reads zero-extended
d_done_o  out  1  one-cycle write complete pulse
mem_value_i  in  16  memory read data, valid one cycle after mem_rd_en_o
mem_addr_o  out  ADDR_WIDTH  memory address
mem_value_o  out  16  memory write data
mem_rd_en_o  out  1  read strobe
mem_wr_en_o  out  1  write strobe
mem_enable_o  out  1  mem_rd_en_o OR mem_wr_en_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, flush-pending flag 0. Reset mid-access abandons it; no gnt, rvalid or done pulses afterwards.
- States: IDLE, LO, HI, RESP.
- Arbitration in IDLE only:
  - Data wins if d_req_i=1, unless if_req_i=1 and counter==STARVE_MAX; then fetch wins.
  - Counter increments on each data grant while if_req_i=1, saturates at STARVE_MAX, clears on fetch grant.
- Winner's addr, we, wide and wdata are latched at the IDLE edge; state goes to LO.
- LO:
  - gnt pulse to the winner.
  - Memory strobe (rd or wr), mem_addr_o=addr, mem_value_o=wdata[15:0] for writes.
  - Next state: HI if wide; else RESP if read; else IDLE with d_done_o pulsing in the following cycle.
- HI:
  - mem_addr_o = addr+1, wrapping modulo 2^ADDR_WIDTH.
  - Read: capture mem_value_i into rdata[15:0], strobe rd, go to RESP.
  - Write: mem_value_o=wdata[31:16], strobe wr, go to IDLE; d_done_o pulses next cycle.
- RESP:
  - Capture mem_value_i into rdata[15:0] for 16-bit or fetch reads, rdata[31:16] for wide reads.
  - Go to IDLE; the rvalid pulse (with data) appears in the following cycle, coinciding with IDLE.
- Latency (grant at cycle 1):
  - 16-bit read: rvalid at cycle 3.
  - 32-bit read: rvalid at cycle 4.
  - 16-bit write: done at cycle 2.
  - 32-bit write: done at cycle 3.
- Strobes are high only in LO/HI, never both at once. Memory outputs are 0 when no strobe is active.
- Flush:
  - if_flush_i=1 in any cycle from fetch LO through RESP sets flush-pending; the resulting if_rvalid_o is suppressed and the flag clears.
  - if_flush_i in IDLE has no effect. The memory access itself is not cancelled.
- Requesters must drop or update req the cycle after gnt. Req seen in non-IDLE states is ignored.
- Simultaneous if_req_i and d_req_i with counter<STARVE_MAX: data granted, fetch waits.

Optional Feature:
MEM_SEQ_PERF_EN:
- Defined: adds outputs if_stall_cnt_o[15:0] (cycles with if_req_i=1 and no if_gnt_o) and d_access_cnt_o[15:0] (data grants). Both are saturating at 16'hFFFF and cleared by rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- 16-bit fetch, if_addr_i=8'h10, mem returns 16'hA5A5 -> if_gnt_o cycle 1, mem_rd_en_o with addr 8'h10 cycle 1, if_rvalid_o with 16'hA5A5 cycle 3.
- 32-bit data read at 8'hFF, mem returns 16'h1234 then 16'h5678 -> addresses 8'hFF then 8'h00, d_rdata_o=32'h5678_1234, d_rvalid_o cycle 4.
- 32-bit write 32'hDEAD_BEEF at 8'h20 -> mem_wr_en_o at 8'h20 with 16'hBEEF then 8'h21 with 16'hDEAD, d_done_o cycle 3, mem_rd_en_o never set.
- if_req_i and d_req_i held high, data re-requests each time, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I.
- Fetch granted, if_flush_i pulsed in RESP -> no if_rvalid_o, next fetch returns data normally.
- rst_i asserted during HI of a wide read -> next cycle all outputs 0, busy_o=0, no d_rvalid_o afterwards.

Source files
------------

// File: rtl/mem_req_sequencer.sv
// Shares one 16-bit memory port between instruction fetch and data requesters,
// splitting 32-bit data accesses into two beats. Optional counters: MEM_SEQ_PERF_EN.
module mem_req_sequencer #(
   parameter int ADDR_WIDTH = 8,
   parameter int STARVE_MAX = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   input  logic                  if_flush_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [15:0]           if_rdata_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic                  d_wide_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [31:0]           d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [31:0]           d_rdata_o,
   output logic                  d_done_o,
   input  logic [15:0]           mem_value_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [15:0]           mem_value_o,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic                  mem_enable_o,
   output logic                  busy_o
`ifdef MEM_SEQ_PERF_EN
   ,
   output logic [15:0]           if_stall_cnt_o,
   output logic [15:0]           d_access_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e                  state_q, state_d;
   logic                    fetch_q, fetch_d;
   logic                    we_q, we_d;
   logic                    wide_q, wide_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    if_rvalid_q, if_rvalid_d;
   logic                    d_rvalid_q, d_rvalid_d;
   logic                    d_done_q, d_done_d;
   logic [3:0]              starve_q, starve_d;
   logic                    flush_q, flush_d;
   logic                    fetch_forced;

   assign fetch_forced = if_req_i && (starve_q == STARVE_LIM);

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d     = state_q;
      fetch_d     = fetch_q;
      we_d        = we_q;
      wide_d      = wide_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      starve_d    = starve_q;
      flush_d     = flush_q;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      d_done_d    = 1'b0;
      if_gnt_o    = 1'b0;
      d_gnt_o     = 1'b0;
      mem_rd_en_o = 1'b0;
      mem_wr_en_o = 1'b0;
      mem_addr_o  = '0;
      mem_value_o = '0;

      unique case (state_q)
         IDLE: begin
            if (d_req_i && !fetch_forced) begin
               fetch_d = 1'b0;
               we_d    = d_we_i;
               wide_d  = d_wide_i;
               addr_d  = d_addr_i;
               wdata_d = d_wdata_i;
               state_d = LO;
               // Only counts while fetch is actually being held off.
               if (if_req_i) starve_d = starve_q + 4'd1;
            end else if (if_req_i) begin
               fetch_d  = 1'b1;
               we_d     = 1'b0;
               wide_d   = 1'b0;
               addr_d   = if_addr_i;
               wdata_d  = '0;
               starve_d = '0;
               state_d  = LO;
            end
         end
         LO: begin
            if_gnt_o   = fetch_q;
            d_gnt_o    = !fetch_q;
            mem_addr_o = addr_q;
            if (we_q) begin
               mem_wr_en_o = 1'b1;
               mem_value_o = wdata_q[15:0];
            end else begin
               mem_rd_en_o = 1'b1;
            end
            if (fetch_q && if_flush_i) flush_d = 1'b1;
            if (wide_q) begin
               state_d = HI;
            end else if (we_q) begin
               state_d  = IDLE;
               d_done_d = 1'b1;
            end else begin
               state_d = RESP;
            end
         end
         HI: begin
            mem_addr_o = addr_q + ADDR_WIDTH'(1);
            if (we_q) begin
               mem_wr_en_o = 1'b1;
               mem_value_o = wdata_q[31:16];
               d_done_d    = 1'b1;
               state_d     = IDLE;
            end else begin
               mem_rd_en_o   = 1'b1;
               rdata_d[15:0] = mem_value_i;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (wide_q) rdata_d[31:16] = mem_value_i;
            else        rdata_d        = {16'h0000, mem_value_i};
            if (fetch_q) begin
               // A flush arriving in this very cycle still kills the response.
               if_rvalid_d = !(flush_q || if_flush_i);
               flush_d     = 1'b0;
            end else begin
               d_rvalid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: datapath registers are reset too because their values reach the output ports.
         state_q     <= IDLE;
         fetch_q     <= 1'b0;
         we_q        <= 1'b0;
         wide_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_done_q    <= 1'b0;
         starve_q    <= '0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_q     <= fetch_d;
         we_q        <= we_d;
         wide_q      <= wide_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         d_done_q    <= d_done_d;
         starve_q    <= starve_d;
         flush_q     <= flush_d;
      end
   end

   assign if_rvalid_o  = if_rvalid_q;
   assign if_rdata_o   = rdata_q[15:0];
   assign d_rvalid_o   = d_rvalid_q;
   assign d_rdata_o    = rdata_q;
   assign d_done_o     = d_done_q;
   assign mem_enable_o = mem_rd_en_o | mem_wr_en_o;
   assign busy_o       = (state_q != IDLE);

`ifdef MEM_SEQ_PERF_EN
   logic [15:0] if_stall_q, if_stall_d;
   logic [15:0] d_access_q, d_access_d;

   always_comb begin
      if_stall_d = if_stall_q;
      d_access_d = d_access_q;
      if (if_req_i && !if_gnt_o && (if_stall_q != 16'hFFFF)) if_stall_d = if_stall_q + 16'd1;
      if (d_gnt_o && (d_access_q != 16'hFFFF))                d_access_d = d_access_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if_stall_q <= '0;
         d_access_q <= '0;
      end else begin
         if_stall_q <= if_stall_d;
         d_access_q <= d_access_d;
      end
   end

   assign if_stall_cnt_o = if_stall_q;
   assign d_access_cnt_o = d_access_q;
`endif

endmodule
